// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU in the execute stage.
// Returns {remainder, quotient} and holds it with ready_o while start_i stays high.
module div_unit #(
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  start_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o
);

  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_FREE    = 2'd0,
    S_BY_ZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [DATA_W-1:0]   rem, rem_nx;
  logic [DATA_W-1:0]   quot, quot_nx;
  logic [DATA_W-1:0]   dvs, dvs_nx;
  logic                sq, sq_nx;
  logic                sr, sr_nx;
  logic [2*DATA_W-1:0] result_nx;
  logic                ready_nx;

  logic                neg1, neg2, last_iter;
  logic [DATA_W-1:0]   mag1, mag2;
  logic [DATA_W:0]     rem_sh, trial;
  logic [DATA_W-1:0]   iter_rem, iter_quot;

  // Operand magnitudes; DIVU leaves both operands untouched
  assign neg1 = signed_div_i & opdata1_i[DATA_W-1];
  assign neg2 = signed_div_i & opdata2_i[DATA_W-1];
  assign mag1 = neg1 ? -opdata1_i : opdata1_i;
  assign mag2 = neg2 ? -opdata2_i : opdata2_i;

  // One restoring step: shift in the next dividend bit, keep the trial if it did not borrow
  assign rem_sh    = {rem, quot[DATA_W-1]};
  assign trial     = rem_sh - {1'b0, dvs};
  assign iter_rem  = trial[DATA_W] ? rem_sh[DATA_W-1:0] : trial[DATA_W-1:0];
  assign iter_quot = {quot[DATA_W-2:0], ~trial[DATA_W]};
  assign last_iter = (cnt == CNT_W'(DATA_W - 1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FREE;
    else      state <= state_nx;
  end

  // Next-state logic; annul overrides every state
  always_comb begin
    state_nx = state;
    if (annul_i) begin
      state_nx = S_FREE;
    end else begin
      case (state)
        S_FREE:    if (start_i) state_nx = (opdata2_i == '0) ? S_BY_ZERO : S_ON;
        S_BY_ZERO: state_nx = S_END;
        S_ON:      if (last_iter) state_nx = S_END;
        S_END:     if (!start_i) state_nx = S_FREE;
        default:   state_nx = S_FREE;
      endcase
    end
  end

  // Datapath and output next values
  always_comb begin
    cnt_nx    = cnt;
    rem_nx    = rem;
    quot_nx   = quot;
    dvs_nx    = dvs;
    sq_nx     = sq;
    sr_nx     = sr;
    result_nx = result_o;
    ready_nx  = ready_o;
    if (annul_i) begin
      cnt_nx    = '0;
      result_nx = '0;
      ready_nx  = 1'b0;
    end else begin
      case (state)
        S_FREE: begin
          result_nx = '0;
          ready_nx  = 1'b0;
          if (start_i) begin
            cnt_nx  = '0;
            rem_nx  = '0;
            quot_nx = mag1;
            dvs_nx  = mag2;
            sq_nx   = neg1 ^ neg2;
            sr_nx   = neg1;
          end
        end
        S_BY_ZERO: begin
          rem_nx  = '0;
          quot_nx = '0;
        end
        S_ON: begin
          cnt_nx = cnt + CNT_W'(1);
          if (last_iter) begin
            quot_nx = sq ? -iter_quot : iter_quot;
            rem_nx  = sr ? -iter_rem : iter_rem;
          end else begin
            quot_nx = iter_quot;
            rem_nx  = iter_rem;
          end
        end
        S_END: begin
          if (start_i) begin
            result_nx = {rem, quot};
            ready_nx  = 1'b1;
          end else begin
            cnt_nx    = '0;
            result_nx = '0;
            ready_nx  = 1'b0;
          end
        end
        default: begin
          result_nx = '0;
          ready_nx  = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      rem      <= '0;
      quot     <= '0;
      dvs      <= '0;
      sq       <= 1'b0;
      sr       <= 1'b0;
      result_o <= '0;
      ready_o  <= 1'b0;
    end else begin
      cnt      <= cnt_nx;
      rem      <= rem_nx;
      quot     <= quot_nx;
      dvs      <= dvs_nx;
      sq       <= sq_nx;
      sr       <= sr_nx;
      result_o <= result_nx;
      ready_o  <= ready_nx;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table, corner sequences, random ops.
module tb_div_unit;

  logic        clk;
  logic        rst_n;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    bit          s;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
  } vec_t;

  vec_t vecs[13];

  div_unit #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst_n), .signed_div_i(signed_div),
    .opdata1_i(op1), .opdata2_i(op2), .start_i(start), .annul_i(annul),
    .result_o(result), .ready_o(ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference using the language's own division operators
  function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
      sa = a; sb = b;
      q = sa / sb;
      r = sa % sb;
      return {32'(r), 32'(q)};
    end
    return {a % b, a / b};
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'hFFFF_FFFF;
      default: return 32'($urandom);
    endcase
  endfunction

  // Wait for ready with a bounded number of edges; returns edges consumed since issue
  task automatic wait_ready(output int n, output bit seen);
    n = 0; seen = 1'b0;
    while (!seen && n < 50) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        op1 = op1 ^ 32'h5A5A_A5A5;
        op2 = op2 + 32'd3;
      end
      if (ready) seen = 1'b1;
    end
  endtask

  // Full transaction: issue, wait, check latency/result, hold, release
  task automatic run_op(input bit s, input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp);
    int n; bit seen; logic [63:0] e;
    @(negedge clk);
    signed_div = s; op1 = a; op2 = b; start = 1'b1;
    exp_q.push_back(exp);
    wait_ready(n, seen);
    if (!seen) begin
      check("ready_timeout", 64'(seen), 64'd1);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      check("latency", 64'(n), (b == 32'd0) ? 64'd3 : 64'd34);
      check("result", result, e);
      @(posedge clk); #1;
      check("hold_ready", 64'(ready), 64'd1);
      check("hold_result", result, e);
    end
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check("release_ready", 64'(ready), 64'd0);
    check("release_result", result, 64'd0);
  endtask

  initial begin
    int n; bit seen; int hits;
    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
    vecs[1]  = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
    vecs[2]  = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
    vecs[3]  = '{1'b1, 32'd5,          32'd0,          32'd0,          32'd0};
    vecs[4]  = '{1'b0, 32'd5,          32'd0,          32'd0,          32'd0};
    vecs[5]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
    vecs[6]  = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
    vecs[7]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0};
    vecs[8]  = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE};
    vecs[9]  = '{1'b0, 32'd0,          32'd5,          32'd0,          32'd0};
    vecs[10] = '{1'b1, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          32'h7FFF_FFFF};
    vecs[11] = '{1'b0, 32'h8000_0000,  32'd7,          32'h1249_2492,  32'd2};
    vecs[12] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000};

    rst_n = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0; start = 1'b0; annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 64'(ready), 64'd0);
    check("reset_result", result, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 13; i++)
      run_op(vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].r, vecs[i].q});

    // Annul mid-operation: no result may appear, next op still correct
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd1000; op2 = 32'd3; start = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk); annul = 1'b1; start = 1'b0;
    @(posedge clk); #1;
    check("annul_ready", 64'(ready), 64'd0);
    check("annul_result", result, 64'd0);
    @(negedge clk); annul = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (ready) hits++;
    end
    check("annul_no_ready", 64'(hits), 64'd0);
    run_op(1'b0, 32'd1000, 32'd3, {32'd1, 32'd333});

    // Annul while a result is being held
    @(negedge clk);
    signed_div = 1'b1; op1 = 32'd50; op2 = 32'd5; start = 1'b1;
    wait_ready(n, seen);
    check("end_ready_seen", 64'(seen), 64'd1);
    @(negedge clk); annul = 1'b1;
    @(posedge clk); #1;
    check("end_annul_ready", 64'(ready), 64'd0);
    check("end_annul_result", result, 64'd0);
    @(negedge clk); annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    check("end_annul_idle", 64'(ready), 64'd0);

    // Asynchronous reset while a result is presented
    @(negedge clk);
    signed_div = 1'b0; op1 = 32'd77; op2 = 32'd10; start = 1'b1;
    wait_ready(n, seen);
    check("rst_end_seen", 64'(seen), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_ready", 64'(ready), 64'd0);
    check("rst_async_result", result, 64'd0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    // Asynchronous reset mid-iteration; following op must see full latency
    @(negedge clk);
    signed_div = 1'b1; op1 = 32'd123456; op2 = 32'd789; start = 1'b1;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_on_ready", 64'(ready), 64'd0);
    start = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_op(1'b1, 32'hFFFE_1DC0, 32'd789, ref_div(1'b1, 32'hFFFE_1DC0, 32'd789));

    // Random DIV/DIVU against the reference model
    for (int i = 0; i < 1000; i++) begin
      bit s; logic [31:0] a, b;
      s = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      run_op(s, a, b, ref_div(s, a, b));
    end

    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
